// File: rtl/hub75_pkg.sv
// Shared HUB75 panel parameters, FSM encoding and pixel type for the driver and receiver.
// Constants only; no logic, no latency, no flow control.
package hub75_pkg;
  localparam int NUM_COLS    = 64;
  localparam int ROW_W       = 5;
  localparam int PLANES      = 4;
  localparam int SYNC_STAGES = 2;
  localparam int ONT_W       = 16;
  localparam int COL_W       = $clog2(NUM_COLS);
  localparam int PL_W        = $clog2(PLANES);
  // One extra bit so the column counter can represent a completely filled line.
  localparam int CNT_W       = COL_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0] rgb0;
    logic [2:0] rgb1;
  } pixel_t;

  function automatic logic [PL_W-1:0] next_plane(input logic [PL_W-1:0] p);
    return (p == PL_W'(PLANES - 1)) ? '0 : p + 1'b1;
  endfunction
endpackage

// File: rtl/hub75_sync_edge.sv
// N-stage synchronizer with rise/fall pulses taken from the last two synced samples.
// Latency STAGES clk to o_q, one more compare for edges; no backpressure, free-running.
module hub75_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= STAGES'({r_sync, i_d});
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] & r_prev;
endmodule

// File: rtl/hub75_rx.sv
// HUB75 receiver: rebuilds shifted lines into {row,col} pixel writes and measures NOE-low time per plane.
// First write SYNC_STAGES+2 clk after latch rises; no backpressure, a latch during drain is dropped and flagged.
module hub75_rx
  import hub75_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_lp_clk,
  input  logic                   i_latch,
  input  logic                   i_noe,
  input  logic [ROW_W-1:0]       i_row,
  input  logic [2:0]             i_rgb0,
  input  logic [2:0]             i_rgb1,
  output logic                   o_wr_en,
  output logic [ROW_W+COL_W-1:0] o_wr_addr,
  output logic [5:0]             o_wr_data,
  output logic [PL_W-1:0]        o_wr_plane,
  output logic                   o_line_done,
  output logic [ONT_W-1:0]       o_on_time,
  output logic                   o_on_valid,
  output logic                   o_err_short,
  output logic                   o_err_long,
  output logic                   o_err_overrun
);
  localparam int BUS_W = ROW_W + 6;

  logic w_lp_q, w_lp_rise, w_lp_fall;
  logic w_latch_q, w_latch_rise, w_latch_fall;
  logic w_noe_s, w_noe_rise, w_noe_fall;
  logic w_unused_edges;

  hub75_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_lp_sync (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_lp_clk),
    .o_q(w_lp_q), .o_rise(w_lp_rise), .o_fall(w_lp_fall)
  );

  hub75_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_latch_sync (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_latch),
    .o_q(w_latch_q), .o_rise(w_latch_rise), .o_fall(w_latch_fall)
  );

  // NOE idles high (dark) so the lit-time counter does not run while leaving reset.
  hub75_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_noe_sync (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_noe),
    .o_q(w_noe_s), .o_rise(w_noe_rise), .o_fall(w_noe_fall)
  );

  assign w_unused_edges = ^{w_lp_q, w_lp_fall, w_latch_q, w_latch_fall, w_noe_rise, w_noe_fall};

  // Row and RGB see the same delay as lp_clk so the rising edge lines up with its data.
  logic [SYNC_STAGES-1:0][BUS_W-1:0] r_bus_s;
  logic [ROW_W-1:0]                  w_row_s;
  pixel_t                            w_pix;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_bus_s <= '0;
    else       r_bus_s <= (SYNC_STAGES * BUS_W)'({r_bus_s, i_row, i_rgb0, i_rgb1});
  end

  assign w_row_s = r_bus_s[SYNC_STAGES-1][BUS_W-1:6];
  assign w_pix   = pixel_t'(r_bus_s[SYNC_STAGES-1][5:0]);

  state_t                     r_state, w_state_next;
  logic [CNT_W-1:0]           r_col, w_col_next;
  logic [COL_W-1:0]           r_k;
  pixel_t [NUM_COLS-1:0]      r_shift_buf, w_buf_next, r_hold_buf;
  logic [ROW_W-1:0]           r_row_l;
  logic                       r_have_row;
  logic [PL_W-1:0]            r_plane;
  logic [ONT_W-1:0]           r_ont;
  logic                       w_col_full, w_shift, w_accept;

  assign w_col_full = (r_col == CNT_W'(NUM_COLS));
  assign w_shift    = w_lp_rise & ~w_col_full;
  assign w_accept   = w_latch_rise & (r_state == IDLE);

  // Shift view including this cycle's pixel, so a coincident latch captures it.
  always_comb begin
    w_buf_next = r_shift_buf;
    w_col_next = r_col;
    if (w_shift) begin
      w_buf_next[r_col[COL_W-1:0]] = w_pix;
      w_col_next                   = r_col + 1'b1;
    end
  end

  logic r_err_short, r_err_long, r_err_overrun;
  logic [ONT_W-1:0] r_on_time;
  logic             r_on_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_col         <= '0;
      r_shift_buf   <= '0;
      r_hold_buf    <= '0;
      r_row_l       <= '0;
      r_have_row    <= 1'b0;
      r_plane       <= '0;
      r_err_short   <= 1'b0;
      r_err_long    <= 1'b0;
      r_err_overrun <= 1'b0;
      r_on_time     <= '0;
      r_on_valid    <= 1'b0;
    end else begin
      r_on_valid <= 1'b0;
      if (w_lp_rise && w_col_full) r_err_long <= 1'b1;
      if (w_latch_rise) begin
        r_col      <= '0;
        r_on_time  <= r_ont;
        r_on_valid <= 1'b1;
        if (w_col_next != CNT_W'(NUM_COLS)) r_err_short <= 1'b1;
        if (r_state != IDLE) begin
          r_err_overrun <= 1'b1;
        end else begin
          r_hold_buf  <= w_buf_next;
          r_shift_buf <= '0;
          r_row_l     <= w_row_s;
          r_have_row  <= 1'b1;
          r_plane     <= (r_have_row && (w_row_s == r_row_l)) ? next_plane(r_plane) : '0;
        end
      end else begin
        r_col       <= w_col_next;
        r_shift_buf <= w_buf_next;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                         r_ont <= '0;
    else if (w_accept)                 r_ont <= '0;
    else if (!w_noe_s && r_ont != '1)  r_ont <= r_ont + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = DRAIN;
      DRAIN:   if (r_k == COL_W'(NUM_COLS - 1)) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  logic                   r_wr_en, r_line_done;
  logic [ROW_W+COL_W-1:0] r_wr_addr;
  logic [5:0]             r_wr_data;
  logic [PL_W-1:0]        r_wr_plane;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_k         <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_wr_plane  <= '0;
      r_line_done <= 1'b0;
    end else begin
      r_wr_en     <= (r_state == DRAIN);
      r_line_done <= (r_state == DONE);
      if (r_state == DRAIN) begin
        r_k        <= r_k + 1'b1;
        r_wr_addr  <= {r_row_l, r_k};
        r_wr_data  <= r_hold_buf[r_k];
        r_wr_plane <= r_plane;
      end else begin
        r_k <= '0;
      end
    end
  end

  assign o_wr_en       = r_wr_en;
  assign o_wr_addr     = r_wr_addr;
  assign o_wr_data     = r_wr_data;
  assign o_wr_plane    = r_wr_plane;
  assign o_line_done   = r_line_done;
  assign o_on_time     = r_on_time;
  assign o_on_valid    = r_on_valid;
  assign o_err_short   = r_err_short;
  assign o_err_long    = r_err_long;
  assign o_err_overrun = r_err_overrun;
endmodule

// File: doc/hub75_rx.md
Name: hub75_rx

Overview:
- Receive-side counterpart of the LED-panel driver: samples the HUB75 pins (LP_CLK, LATCH, NOE, ROW, RGB0, RGB1) in the system clock domain.
- Reconstructs each shifted line and emits it as a stream of pixel writes tagged with row, column and bit-plane.
- Measures NOE-low (lit) time per plane.
- Used as a loop-back checker in simulation and as a capture block on a second board for daisy-chain and debug.

Parameters:
- NUM_COLS, 64: pixels shifted per line; COL_W = clog2(NUM_COLS).
- ROW_W, 5: width of ROW bus (32 row pairs).
- PLANES, 4: bit-planes per row; PL_W = clog2(PLANES).
- SYNC_STAGES, 2: synchronizer depth on all pin inputs.
- ONT_W, 16: width of the lit-time counter.

Ports:
- clk, in, 1: system clock. Must be ≥ 4× the LP_CLK toggle rate.
- rst, in, 1: asynchronous, active-high reset.
- lp_clk, in, 1: panel shift clock; data is valid on its rising edge.
- latch, in, 1: line latch. Active-high at the pin, already inverted by the driver.
- noe, in, 1: output enable, active-low.
- row, in, ROW_W: row address.
- rgb0, in, 3: upper-half pixel.
- rgb1, in, 3: lower-half pixel.
- wr_en, out, 1: one-cycle pixel write strobe.
- wr_addr, out, ROW_W+COL_W: {row, col}.
- wr_data, out, 6: {rgb0, rgb1}.
- wr_plane, out, PL_W: bit-plane index of the current write.
- line_done, out, 1: pulses one cycle after the last write of a line.
- on_time, out, ONT_W: NOE-low clk count for the last plane. Saturating.
- on_valid, out, 1: pulses when on_time updates.
- err_short, out, 1: sticky. A latch arrived with fewer than NUM_COLS shifts.
- err_long, out, 1: sticky. More than NUM_COLS shifts arrived before a latch.
- err_overrun, out, 1: sticky. A latch arrived while the previous line was still draining.

Behaviour:
- Reset: all outputs are 0; col counter, plane counter, buffers and sticky errors are cleared; FSM goes to IDLE. Reset mid-line discards the partial line with no writes.
- Input path: every pin passes through SYNC_STAGES flops; row and rgb share the same delay as lp_clk. Edges are detected from the last two synced samples.
- Shift:
  - On lp_clk rising edge, store {rgb0, rgb1} into shift_buf[col] and increment col.
  - At col == NUM_COLS, further edges are ignored and err_long is set; col holds.
- Latch, on rising edge:
  - If col != NUM_COLS, set err_short. The line is still transferred; unfilled entries are 0.
  - If the FSM is not IDLE, set err_overrun and drop the new line; buffers stay untouched except that col is reset.
  - Otherwise copy shift_buf to hold_buf, capture row_l = synced row, and start DRAIN.
  - col always resets to 0.
  - Plane tracking: if row_l equals the previous row_l, the plane increments, wrapping at PLANES-1 → 0; otherwise the plane is 0.
- FSM:
  - IDLE → DRAIN on an accepted latch.
  - DRAIN: wr_en = 1 for NUM_COLS consecutive cycles, with wr_addr = {row_l, k} and wr_data = hold_buf[k] for k = 0..NUM_COLS-1.
  - DRAIN → DONE after k = NUM_COLS-1.
  - DONE: line_done = 1 for one cycle, then → IDLE.
  - Latency: the first wr_en comes SYNC_STAGES+2 clk after the latch pin rises.
- An lp_clk edge and a latch edge in the same sample cycle: the shift is applied first, then the latch, so the pixel belongs to the latched line.
- Lit time:
  - The counter clears on each accepted latch and increments each clk while synced noe = 0, saturating at 2^ONT_W-1.
  - On the next latch edge, on_time takes the counter value for the previous plane and on_valid pulses, before the clear.
- Error flags clear only on rst.

Decomposition:
- Package hub75_pkg: NUM_COLS, ROW_W, PLANES, derived COL_W/PL_W, FSM state encoding (IDLE, DRAIN, DONE), pixel type (6-bit {rgb0, rgb1}). The driver side shares the same package.
- One sub-module: hub75_sync_edge, an N-stage synchronizer with rise/fall pulse outputs, instantiated for lp_clk, latch and noe. The data buses use the plain sync stages only.

Test Plan:
- Full line: 64 lp_clk edges with pixel k = k[5:0], row = 3, then latch → 64 writes, wr_addr = 0xC0..0xFF, wr_data = k, wr_plane = 0, line_done once, no errors.
- Planes: four latches on row 7, then one on row 8 → wr_plane sequence 0, 1, 2, 3 then 0.
- Short line: 10 shifts, then latch → err_short = 1, writes for cols 10..63 carry 0.
- Long line: 70 shifts, then latch → err_long = 1, only the first 64 pixels are written.
- Overrun and lit time:
  - A second latch 20 clk after the first → err_overrun = 1, exactly 64 writes total.
  - noe held low for 500 clk between latches → on_time = 500 with an on_valid pulse.
- Async reset asserted mid-DRAIN → wr_en drops to 0 immediately, no line_done, state IDLE, errors cleared.
